adder4_seq_ctrl: RTL
====================

// Module: adder4_seq_ctrl
//
// PURPOSE
// Sequencer that performs N_DIGITS*4-bit add/subtract by time-multiplexing one
// external 4-bit adder (a, b, ci -> s, co) one nibble per clock, LSB nibble first.
// Latches operands on a start pulse, feeds the adder, collects sum nibbles and the
// ripple carry, then signals done. Sits between a requester and one adder4 instance.
//
// PARAMETERS
// N_DIGITS  4  number of 4-bit nibbles per operand (operand width W = 4*N_DIGITS), >=1
//
// PORTS
// clk      in   1      clock, all state updates on rising edge
// reset    in   1      synchronous, active-high reset
// start    in   1      request; sampled only when state is IDLE or DONE
// sub      in   1      0: x+y+cin; 1: x-y (y inverted, carry-in forced 1, cin ignored)
// x        in   W      operand A, latched with start
// y        in   W      operand B, latched with start
// cin      in   1      carry-in for add mode, latched with start
// busy     out  1      high while state is RUN
// done     out  1      one-cycle pulse: result valid
// sum      out  W      result; held stable from done until next accepted start
// cout     out  1      final carry out (sub mode: 1 = no borrow)
// add_a    out  4      to adder: current x nibble
// add_b    out  4      to adder: current y nibble (inverted when sub)
// add_ci   out  1      to adder: carry register
// add_s    in   4      from adder: nibble sum (combinational, same cycle)
// add_co   in   1      from adder: nibble carry out
//
// BEHAVIOUR
// - States: IDLE, RUN, DONE. Reset (sync, any state): IDLE, cnt=0, carry=0,
//   sum=0, cout=0, busy=0, done=0, operand regs=0.
// - IDLE/DONE with start=1: latch x, y^{W{sub}}, carry<=sub?1:cin, cnt<=0, clear
//   sum to 0 -> RUN. Without start: DONE -> IDLE, IDLE stays.
// - RUN, each cycle: add_a=xr[4*cnt+:4], add_b=yr[4*cnt+:4], add_ci=carry.
//   At edge: sum[4*cnt+:4]<=add_s, carry<=add_co, cnt<=cnt+1.
//   When cnt==N_DIGITS-1: cout<=add_co, cnt<=0 -> DONE.
// - DONE: done=1 for exactly that cycle; busy=0.
// - Latency: start sampled at edge E0 -> done high in the cycle after edge E(N_DIGITS).
//   Back-to-back: start during DONE accepted, so throughput is N_DIGITS+1 cycles/op.
// - start while RUN: ignored (no queue, no effect on operands or cnt).
// - add_a/add_b/add_ci driven 0 outside RUN.
// - Width: cnt is $clog2(N_DIGITS) bits (min 1). cnt never exceeds N_DIGITS-1.
// - Result = (xr + yr + carry_in) mod 2^W, cout = bit W; wrap-around is not an error.
// - Reset mid-RUN: aborts, outputs return to reset values next cycle; no done pulse.
//
// TESTING (N_DIGITS=4, bench instantiates adder4_logic on add_* ports)
// 1 x=1234h y=4321h cin=0 sub=0 -> add_a seq 4,3,2,1; done 4 cycles after start
//   edge; sum=5555h cout=0
// 2 x=FFFFh y=0001h cin=0 -> sum=0000h cout=1 (carry ripples across all nibbles);
//   x=0000h y=0000h cin=1 -> sum=0001h cout=0
// 3 sub=1 x=0005h y=0007h -> sum=FFFEh cout=0; sub=1 x=0007h y=0005h -> 0002h cout=1
// 4 start again 2 cycles into RUN with different x/y -> ignored, result of first op
//   only, exactly one done pulse
// 5 reset during RUN (cnt=2) -> next cycle busy=0 done=0 sum=0 cout=0; new op then ok
// 6 start held high through DONE -> second op accepted, done pulses 5 cycles apart,
//   sum of first op stable until second start accepted

Source files
------------

// File: rtl/adder4_seq_ctrl.sv
// adder4_seq_ctrl: multi-nibble add/subtract sequencer driving one external
// 4-bit adder, one nibble per clock, least significant nibble first.
module adder4_seq_ctrl #(
    parameter int unsigned N_DIGITS = 4,
    localparam int unsigned W = 4 * N_DIGITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_ci,
    input  logic [3:0]   add_s,
    input  logic         add_co
);

    localparam int unsigned CntW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            carry;
    logic [W-1:0]    xr;
    logic [W-1:0]    yr;

    // Sequencer state, operand latches, result assembly and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= '0;
            carry <= 1'b0;
            xr    <= '0;
            yr    <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= x;
                        // Subtraction is x + ~y + 1: invert y here, force carry-in.
                        yr    <= y ^ {W{sub}};
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    sum[4*cnt +: 4] <= add_s;
                    carry           <= add_co;
                    if (cnt == CntMax) begin
                        cout  <= add_co;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Adder operands: current nibble while running, quiet zeros otherwise.
    always_comb begin
        add_a  = 4'h0;
        add_b  = 4'h0;
        add_ci = 1'b0;
        if (state == StRun) begin
            add_a  = xr[4*cnt +: 4];
            add_b  = yr[4*cnt +: 4];
            add_ci = carry;
        end
    end

endmodule
